// File: rtl/tl_axi_pkg.sv
// Shared AXI constants and types for the TL-UL to AXI4 write path.
package tl_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Widest ID the command ring can hold; narrower IDs are zero-extended.
    localparam int CMD_ID_W = 32;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } w_state_t;

    typedef struct packed {
        logic [CMD_ID_W-1:0] id;
        logic [7:0]          len;
    } wr_cmd_t;

endpackage

// File: rtl/axi4_wr_data_resp.sv
// Issues AXI4 W beats for each accepted write command and retires the B
// response in order, returning an ID + error completion to the bridge.
module axi4_wr_data_resp
    import tl_axi_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter int IdWidth   = 8,
    parameter int Depth     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [IdWidth-1:0]     cmd_id,
    input  logic [7:0]             cmd_len,

    input  logic                   wd_valid,
    output logic                   wd_ready,
    input  logic [DataWidth-1:0]   wd_data,
    input  logic [DataWidth/8-1:0] wd_strb,

    output logic [DataWidth-1:0]   axi_wdata,
    output logic [DataWidth/8-1:0] axi_wstrb,
    output logic                   axi_wlast,
    output logic                   axi_wvalid,
    input  logic                   axi_wready,

    input  logic [IdWidth-1:0]     axi_bid,
    input  logic [1:0]             axi_bresp,
    input  logic                   axi_bvalid,
    output logic                   axi_bready,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IdWidth-1:0]     rsp_id,
    output logic                   rsp_error,

    output logic                   err_proto
);

    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(Depth);

    logic [PW-1:0] wr_ptr, w_ptr, b_ptr;
    logic [PW-1:0] wr_ptr_nxt, w_ptr_nxt;
    wr_cmd_t       ring [Depth];
    w_state_t      w_state;
    logic [7:0]    beat_cnt;

    logic               rsp_valid_q, rsp_err_q, err_q;
    logic [IdWidth-1:0] rsp_id_q;

    logic          full, push, in_burst, beat_hs, last_hs, b_hs, b_has_w, id_mis, resp_err;
    logic [7:0]    w_len;
    wr_cmd_t       head;

    always_comb begin
        full      = (wr_ptr - b_ptr) == DEPTH_P;
        cmd_ready = !full && !rst_i;
        push      = cmd_valid && cmd_ready;

        in_burst   = (w_state == W_BURST) && !rst_i;
        w_len      = ring[w_ptr[AW-1:0]].len;
        axi_wvalid = wd_valid && in_burst;
        wd_ready   = axi_wready && in_burst;
        axi_wdata  = wd_data;
        axi_wstrb  = wd_strb;
        axi_wlast  = in_burst && (beat_cnt == w_len);
        beat_hs    = axi_wvalid && axi_wready;
        last_hs    = beat_hs && axi_wlast;

        axi_bready = !rst_i && (!rsp_valid_q || rsp_ready);
        b_hs       = axi_bvalid && axi_bready;
        head       = ring[b_ptr[AW-1:0]];
        b_has_w    = b_ptr != w_ptr;
        id_mis     = head.id != CMD_ID_W'(axi_bid);
        resp_err   = (axi_bresp == RESP_SLVERR) || (axi_bresp == RESP_DECERR);

        wr_ptr_nxt = wr_ptr + {{(PW-1){1'b0}}, push};
        w_ptr_nxt  = w_ptr + {{(PW-1){1'b0}}, last_hs};

        rsp_valid = rsp_valid_q && !rst_i;
        rsp_id    = rsp_id_q;
        rsp_error = rsp_err_q;
        err_proto = err_q && !rst_i;
    end

    // Ring payload needs no reset: entries are only read between b_ptr and wr_ptr.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ring[wr_ptr[AW-1:0]] <= '{id: CMD_ID_W'(cmd_id), len: cmd_len};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            w_ptr       <= '0;
            b_ptr       <= '0;
            beat_cnt    <= '0;
            w_state     <= W_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            w_ptr   <= w_ptr_nxt;
            w_state <= (w_ptr_nxt != wr_ptr_nxt) ? W_BURST : W_IDLE;

            if (last_hs) begin
                beat_cnt <= '0;
            end else if (beat_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
            end

            err_q <= 1'b0;
            if (b_hs) begin
                rsp_valid_q <= 1'b1;
                if (b_has_w) begin
                    rsp_id_q  <= IdWidth'(head.id);
                    rsp_err_q <= resp_err || id_mis;
                    err_q     <= id_mis;
                    b_ptr     <= b_ptr + 1'b1;
                end else begin
                    // B with no completed W burst: report it, leave the ring alone.
                    rsp_id_q  <= axi_bid;
                    rsp_err_q <= 1'b1;
                    err_q     <= 1'b1;
                end
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_wr_data_resp.sv
// Scoreboard bench for axi4_wr_data_resp: W beats and completions are
// captured mid-cycle and matched against queues filled when stimulus is driven.
module tb_axi4_wr_data_resp;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_id, cmd_len;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wlast, axi_wvalid, axi_wready;
    logic [7:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid, axi_bready;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_id;
    logic        rsp_error, err_proto;

    axi4_wr_data_resp #(.DataWidth(64), .IdWidth(8), .Depth(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_error(rsp_error),
        .err_proto(err_proto)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [63:0] d; logic [7:0] s; logic l; } beat_t;
    typedef struct { logic [7:0] id; logic err; } rsp_t;

    beat_t wq[$], wobs[$];
    rsp_t  rq[$], robs[$];
    int    checks = 0, failures = 0;
    int    mirror_err = 0;

    // Inputs change 1 time unit after posedge, so mid-cycle values are what the next edge sees.
    always @(negedge clk_i) begin
        if (!rst_i && axi_wvalid && axi_wready) wobs.push_back('{axi_wdata, axi_wstrb, axi_wlast});
        if (!rst_i && rsp_valid && rsp_ready) robs.push_back('{rsp_id, rsp_error});
    end

    task automatic cyc();
        @(posedge clk_i); #1;
    endtask

    task automatic timeout(input string what);
        checks++; failures++;
        $display("FAIL %s: timed out waiting, required handshake within bound", what);
    endtask

    task automatic push_cmd(input logic [7:0] id, input logic [7:0] len);
        bit ok = 0;
        cmd_valid = 1; cmd_id = id; cmd_len = len;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk_i);
            ok = cmd_ready;
            cyc();
        end
        cmd_valid = 0;
        if (!ok) timeout("cmd_push");
    endtask

    // mode 0: wready always 1; mode 1: wready toggles 1,0,1,0...
    task automatic send_beats(input int n, input int mode, input int blen, output int cycles);
        int pat = 0;
        cycles = 0;
        for (int i = 0; i < n; i++) begin
            bit hs = 0;
            wd_valid = 1;
            wd_data  = {$urandom, $urandom};
            wd_strb  = 8'($urandom);
            wq.push_back('{wd_data, wd_strb, (i % (blen + 1)) == blen});
            for (int k = 0; k < 40 && !hs; k++) begin
                axi_wready = (mode == 0) ? 1'b1 : ((pat % 2) == 0);
                pat++;
                @(negedge clk_i);
                if (wd_ready !== axi_wready) mirror_err++;
                hs = axi_wvalid && axi_wready;
                cycles++;
                cyc();
            end
            if (!hs) timeout("w_beat");
        end
        wd_valid = 0; axi_wready = 1;
    endtask

    task automatic send_b(input logic [7:0] bid, input logic [1:0] resp);
        bit ok = 0;
        axi_bvalid = 1; axi_bid = bid; axi_bresp = resp;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk_i);
            ok = axi_bready;
            cyc();
        end
        axi_bvalid = 0;
        if (!ok) timeout("b_handshake");
    endtask

    task automatic apply_reset();
        rst_i = 1; cmd_valid = 0; cmd_id = 0; cmd_len = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; axi_wready = 1;
        axi_bvalid = 0; axi_bid = 0; axi_bresp = 0; rsp_ready = 1;
        cyc(); cyc();
        rst_i = 0;
        cyc();
    endtask

    task automatic test_reset();
        rst_i = 1; cmd_valid = 0; wd_valid = 1; axi_wready = 1; axi_bvalid = 0; rsp_ready = 1;
        cyc();
        @(negedge clk_i);
        checks++;
        if ({cmd_ready, wd_ready, axi_wvalid, axi_bready, rsp_valid, err_proto} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 000000",
                {cmd_ready, wd_ready, axi_wvalid, axi_bready, rsp_valid, err_proto});
        end
        cyc();
        rst_i = 0; wd_valid = 0;
        @(negedge clk_i);
        checks++;
        if ({cmd_ready, wd_ready, axi_wvalid, axi_bready, rsp_valid, err_proto} !== 6'b100100) begin
            failures++;
            $display("FAIL post_reset: got %b required 100100",
                {cmd_ready, wd_ready, axi_wvalid, axi_bready, rsp_valid, err_proto});
        end
        cyc();
    endtask

    task automatic test_single_beat();
        beat_t e, o;
        rsp_t  er, orr;
        push_cmd(8'h12, 8'd0);
        wd_valid = 1; wd_data = 64'hDEADBEEF_CAFEF00D; wd_strb = 8'hFF; axi_wready = 1;
        wq.push_back('{64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1});
        @(negedge clk_i);
        checks++;
        if (wd_ready !== 1'b1) begin
            failures++; $display("FAIL single_first_beat_ready: got %b required 1", wd_ready);
        end
        cyc();
        wd_valid = 0;
        cyc();
        checks++;
        if (wobs.size() != 1) begin
            failures++; $display("FAIL single_beat_count: got %0d required 1", wobs.size());
        end
        while (wobs.size() > 0 && wq.size() > 0) begin
            e = wq.pop_front(); o = wobs.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single_beat_data: got %h/%h/%b required %h/%h/%b", o.d, o.s, o.l, e.d, e.s, e.l);
            end
        end
        wq.delete(); wobs.delete();
        rq.push_back('{8'h12, 1'b0});
        send_b(8'h12, 2'b00);
        checks++;
        if (rsp_valid !== 1'b1 || err_proto !== 1'b0) begin
            failures++; $display("FAIL single_rsp_latency: got valid=%b err_proto=%b required 1/0", rsp_valid, err_proto);
        end
        cyc();
        checks++;
        if (robs.size() != 1) begin
            failures++; $display("FAIL single_rsp_count: got %0d required 1", robs.size());
        end else begin
            er = rq.pop_front(); orr = robs.pop_front();
            checks++;
            if (orr !== er) begin
                failures++; $display("FAIL single_rsp: got id=%h err=%b required id=%h err=%b", orr.id, orr.err, er.id, er.err);
            end
        end
        rq.delete(); robs.delete();
    endtask

    task automatic check_queues(input string tag);
        // Called only at the end of a scenario to drain both scoreboards.
        beat_t e, o;
        rsp_t  er, orr;
        checks++;
        if (wobs.size() != wq.size() || robs.size() != rq.size()) begin
            failures++;
            $display("FAIL %s_counts: got beats=%0d rsps=%0d required beats=%0d rsps=%0d",
                tag, wobs.size(), robs.size(), wq.size(), rq.size());
        end
        while (wobs.size() > 0 && wq.size() > 0) begin
            e = wq.pop_front(); o = wobs.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s_beat: got %h/%h/%b required %h/%h/%b", tag, o.d, o.s, o.l, e.d, e.s, e.l);
            end
        end
        while (robs.size() > 0 && rq.size() > 0) begin
            er = rq.pop_front(); orr = robs.pop_front();
            checks++;
            if (orr !== er) begin
                failures++;
                $display("FAIL %s_rsp: got id=%h err=%b required id=%h err=%b", tag, orr.id, orr.err, er.id, er.err);
            end
        end
        wq.delete(); wobs.delete(); rq.delete(); robs.delete();
    endtask

    task automatic test_burst_stall();
        int c;
        wd_valid = 1; axi_wready = 1;
        @(negedge clk_i);
        checks++;
        if (wd_ready !== 1'b0 || axi_wvalid !== 1'b0) begin
            failures++; $display("FAIL idle_no_leak: got ready=%b wvalid=%b required 0/0", wd_ready, axi_wvalid);
        end
        cyc();
        wd_valid = 0;
        push_cmd(8'h21, 8'd3);
        mirror_err = 0;
        send_beats(4, 1, 3, c);
        checks++;
        if (mirror_err != 0) begin
            failures++; $display("FAIL stall_mirror: got %0d mismatched cycles required 0", mirror_err);
        end
        rq.push_back('{8'h21, 1'b0});
        send_b(8'h21, 2'b00);
        cyc();
        check_queues("burst_stall");
    endtask

    task automatic test_full_ring();
        int c;
        for (int i = 1; i <= 4; i++) push_cmd(8'(i), 8'd0);
        @(negedge clk_i);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++; $display("FAIL full_cmd_ready: got %b required 0", cmd_ready);
        end
        cyc();
        cmd_valid = 1; cmd_id = 8'h05; cmd_len = 0;
        send_beats(1, 0, 0, c);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++; $display("FAIL full_fifth_waits: got %b required 0", cmd_ready);
        end
        rq.push_back('{8'h01, 1'b0});
        send_b(8'h01, 2'b00);
        @(negedge clk_i);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL full_slot_freed: got %b required 1", cmd_ready);
        end
        cyc();
        cmd_valid = 0;
        for (int i = 2; i <= 5; i++) begin
            send_beats(1, 0, 0, c);
            rq.push_back('{8'(i), 1'b0});
            send_b(8'(i), 2'b00);
        end
        cyc();
        check_queues("full_ring");
    endtask

    task automatic test_errors();
        int c;
        rq.push_back('{8'h55, 1'b1});
        send_b(8'h55, 2'b00);
        checks++;
        if (err_proto !== 1'b1) begin
            failures++; $display("FAIL orphan_b_err_proto: got %b required 1", err_proto);
        end
        cyc();
        checks++;
        if (err_proto !== 1'b0) begin
            failures++; $display("FAIL err_proto_one_cycle: got %b required 0", err_proto);
        end
        push_cmd(8'h12, 8'd0);
        send_beats(1, 0, 0, c);
        rq.push_back('{8'h12, 1'b1});
        send_b(8'h34, 2'b00);
        checks++;
        if (err_proto !== 1'b1) begin
            failures++; $display("FAIL bid_mismatch_err_proto: got %b required 1", err_proto);
        end
        push_cmd(8'h40, 8'd1);
        send_beats(2, 0, 1, c);
        rq.push_back('{8'h40, 1'b1});
        send_b(8'h40, 2'b10);
        checks++;
        if (err_proto !== 1'b0) begin
            failures++; $display("FAIL slverr_no_proto: got %b required 0", err_proto);
        end
        push_cmd(8'h41, 8'd0);
        push_cmd(8'h42, 8'd0);
        send_beats(2, 0, 0, c);
        rq.push_back('{8'h41, 1'b0});
        send_b(8'h41, 2'b01);
        rq.push_back('{8'h42, 1'b1});
        send_b(8'h42, 2'b11);
        cyc();
        check_queues("errors");
    endtask

    task automatic test_backpressure();
        int c;
        push_cmd(8'h61, 8'd0);
        push_cmd(8'h62, 8'd0);
        send_beats(2, 0, 0, c);
        rsp_ready = 0;
        rq.push_back('{8'h61, 1'b0});
        send_b(8'h61, 2'b00);
        axi_bvalid = 1; axi_bid = 8'h62; axi_bresp = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checks++;
            if (axi_bready !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 8'h61) begin
                failures++;
                $display("FAIL bp_hold: got bready=%b valid=%b id=%h required 0/1/61", axi_bready, rsp_valid, rsp_id);
            end
            cyc();
        end
        rsp_ready = 1;
        rq.push_back('{8'h62, 1'b0});
        @(negedge clk_i);
        checks++;
        if (axi_bready !== 1'b1) begin
            failures++; $display("FAIL bp_release: got %b required 1", axi_bready);
        end
        cyc();
        axi_bvalid = 0;
        cyc(); cyc();
        check_queues("backpressure");
    endtask

    task automatic test_back_to_back();
        int c;
        push_cmd(8'h71, 8'd1);
        push_cmd(8'h72, 8'd1);
        send_beats(4, 0, 1, c);
        checks++;
        if (c != 4) begin
            failures++; $display("FAIL b2b_no_bubble: got %0d cycles required 4", c);
        end
        rq.push_back('{8'h71, 1'b0});
        rq.push_back('{8'h72, 1'b0});
        axi_bvalid = 1; axi_bid = 8'h71; axi_bresp = 2'b00;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            checks++;
            if (axi_bready !== 1'b1) begin
                failures++; $display("FAIL b2b_bready: got %b required 1", axi_bready);
            end
            cyc();
            axi_bid = 8'h72;
        end
        axi_bvalid = 0;
        cyc(); cyc();
        check_queues("back_to_back");
    endtask

    task automatic test_reset_mid_burst();
        int c;
        push_cmd(8'h81, 8'd3);
        wd_valid = 1; axi_wready = 1; wd_data = 64'h1111_2222_3333_4444; wd_strb = 8'h0F;
        wq.push_back('{64'h1111_2222_3333_4444, 8'h0F, 1'b0});
        cyc();
        wd_data = 64'h5555_6666_7777_8888; rst_i = 1;
        @(negedge clk_i);
        checks++;
        if ({cmd_ready, wd_ready, axi_wvalid, axi_bready, rsp_valid, err_proto} !== 6'b0) begin
            failures++;
            $display("FAIL midburst_reset_outputs: got %b required 000000",
                {cmd_ready, wd_ready, axi_wvalid, axi_bready, rsp_valid, err_proto});
        end
        cyc();
        rst_i = 0; wd_valid = 0;
        @(negedge clk_i);
        checks++;
        if (cmd_ready !== 1'b1 || axi_wvalid !== 1'b0) begin
            failures++; $display("FAIL midburst_recover: got ready=%b wvalid=%b required 1/0", cmd_ready, axi_wvalid);
        end
        cyc();
        push_cmd(8'h82, 8'd0);
        send_beats(1, 0, 0, c);
        rq.push_back('{8'h82, 1'b0});
        send_b(8'h82, 2'b00);
        cyc();
        check_queues("reset_mid_burst");
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_single_beat();
        test_burst_stall();
        test_full_ring();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
